mem_arbiter: RTL and testbench

//  Shares the F100-L single-port word memory bus between two requesters: port A (CPU

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module  : mem_arbiter
// Brief   : Two-port arbiter for the single-port word memory bus, fixed
//           priority to port A with a starvation guard for port B.
// Revision: 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_b
);

    localparam logic [2:0] LAT_LAST   = READ_LATENCY[2:0];
    localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_we_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   a_rdata_q;
    logic [DATA_WIDTH-1:0]   b_rdata_q;
    logic                    a_ack_q;
    logic                    b_ack_q;
    logic                    busy_q;
    logic                    grant_b_q;
    logic                    wr_q;
    logic [2:0]              lat_cnt_q;
    logic [3:0]              starve_cnt_q;

    logic                    b_wins_d;
    logic [3:0]              starve_cnt_d;

    // B only overtakes a pending A once A has been granted STARVE_LIMIT times in a row.
    always_comb begin
        b_wins_d     = b_req && (!a_req || (starve_cnt_q == STARVE_MAX));
        starve_cnt_d = starve_cnt_q;
        if (b_wins_d) begin
            starve_cnt_d = 4'd0;
        end else if (a_req) begin
            if (!b_req) begin
                starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            grant_b_q    <= 1'b0;
            wr_q         <= 1'b0;
            lat_cnt_q    <= 3'd0;
            starve_cnt_q <= 4'd0;
        end else begin
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        grant_b_q    <= b_wins_d;
                        mem_addr_q   <= b_wins_d ? b_addr  : a_addr;
                        mem_we_q     <= b_wins_d ? b_we    : a_we;
                        mem_wdata_q  <= b_wins_d ? b_wdata : a_wdata;
                        wr_q         <= b_wins_d ? b_we    : a_we;
                        lat_cnt_q    <= 3'd0;
                        starve_cnt_q <= starve_cnt_d;
                        busy_q       <= 1'b1;
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (wr_q) begin
                        a_ack_q <= !grant_b_q;
                        b_ack_q <= grant_b_q;
                        state_q <= S_ACK;
                    end else if (lat_cnt_q == LAT_LAST) begin
                        // Last ACCESS cycle: read data is valid on the bus now.
                        if (grant_b_q) begin
                            b_rdata_q <= mem_rdata;
                            b_ack_q   <= 1'b1;
                        end else begin
                            a_rdata_q <= mem_rdata;
                            a_ack_q   <= 1'b1;
                        end
                        state_q <= S_ACK;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign busy      = busy_q;
    assign grant_b   = grant_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed scoreboard bench for mem_arbiter; instance 0 uses a read
//           latency of 1, instance 1 a read latency of 3.
// Revision: 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          mem_clr;
    logic          a_req     [2];
    logic          a_we      [2];
    logic [AW-1:0] a_addr    [2];
    logic [DW-1:0] a_wdata   [2];
    logic          a_ack     [2];
    logic [DW-1:0] a_rdata   [2];
    logic          b_req     [2];
    logic          b_we      [2];
    logic [AW-1:0] b_addr    [2];
    logic [DW-1:0] b_wdata   [2];
    logic          b_ack     [2];
    logic [DW-1:0] b_rdata   [2];
    logic [AW-1:0] mem_addr  [2];
    logic          mem_we    [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          busy      [2];
    logic          grant_b   [2];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .reset(reset),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant_b(grant_b[0])
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .reset(reset),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant_b(grant_b[1])
    );

    // Memory model: unwritten words read as 0x1000+addr, except word 1 = 0x0019.
    logic [DW-1:0] mem_arr [2][512];
    logic          wr_flag [2][512];
    logic [DW-1:0] pipe    [2][3];

    function automatic logic [DW-1:0] dflt(input logic [8:0] a);
        return (a == 9'd1) ? 16'h0019 : (16'h1000 + {7'd0, a});
    endfunction

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr) begin
                for (int a = 0; a < 512; a++) wr_flag[k][a] <= 1'b0;
            end else if (mem_we[k]) begin
                mem_arr[k][mem_addr[k][8:0]] <= mem_wdata[k];
                wr_flag[k][mem_addr[k][8:0]] <= 1'b1;
            end
            pipe[k][0] <= wr_flag[k][mem_addr[k][8:0]] ? mem_arr[k][mem_addr[k][8:0]]
                                                      : dflt(mem_addr[k][8:0]);
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ack(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ack_port", {30'd0, a_ack[k], b_ack[k]}, e.port ? 32'd1 : 32'd2);
            chk("grant_b", {31'd0, grant_b[k]}, {31'd0, e.port});
            chk("rdata", {16'd0, e.port ? b_rdata[k] : a_rdata[k]}, {16'd0, e.data});
        end
    endtask

    task automatic do_access(input int k, input logic port, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rd, input int lat, input bit early_drop);
        int n;
        bit done;
        exp_t e;
        @(negedge clk);
        e.port = port;
        e.data = we ? (port ? b_rdata[k] : a_rdata[k]) : rd;
        if (!port) begin
            a_req[k] = 1'b1; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wd;
        end else begin
            b_req[k] = 1'b1; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = wd;
        end
        sb.push_back(e);
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                chk("mem_addr_t1", {17'd0, mem_addr[k]}, {17'd0, addr});
                chk("mem_we_t1", {31'd0, mem_we[k]}, {31'd0, we});
                chk("busy_t1", {31'd0, busy[k]}, 32'd1);
                if (we) chk("mem_wdata", {16'd0, mem_wdata[k]}, {16'd0, wd});
                if (early_drop) begin a_req[k] = 1'b0; b_req[k] = 1'b0; end
            end
            if (n == 2 && we) chk("mem_we_t2", {31'd0, mem_we[k]}, 32'd0);
            if (a_ack[k] || b_ack[k]) begin
                done = 1'b1;
                chk("ack_latency", n, lat);
                check_ack(k);
                a_req[k] = 1'b0;
                b_req[k] = 1'b0;
            end
        end
        if (!done) begin
            chk("ack_timeout", 32'd0, 32'd1);
            a_req[k] = 1'b0;
            b_req[k] = 1'b0;
            void'(sb.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        chk("ack_one_pulse", {30'd0, a_ack[k], b_ack[k]}, 32'd0);
        chk("busy_idle", {31'd0, busy[k]}, 32'd0);
    endtask

    task automatic wait_acks(input int k, input int nacks, input bit drop);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < nacks && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (a_ack[k] || b_ack[k]) begin
                got++;
                check_ack(k);
                if (drop && a_ack[k]) a_req[k] = 1'b0;
                if (drop && b_ack[k]) b_req[k] = 1'b0;
            end
        end
        if (got < nacks) begin
            chk("acks_timeout", got, nacks);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        reset   = 1'b1;
        mem_clr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_req[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0;
            b_req[k] = 1'b0; b_we[k] = 1'b0; b_addr[k] = '0; b_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_addr", {17'd0, mem_addr[k]}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we[k]}, 32'd0);
            chk("rst_mem_wdata", {16'd0, mem_wdata[k]}, 32'd0);
            chk("rst_acks", {30'd0, a_ack[k], b_ack[k]}, 32'd0);
            chk("rst_rdata", {a_rdata[k], b_rdata[k]}, 32'd0);
            chk("rst_busy_grant", {30'd0, busy[k], grant_b[k]}, 32'd0);
        end
        reset   = 1'b0;
        mem_clr = 1'b0;

        // Basic read, write by B, read-back by A.
        do_access(0, 1'b0, 1'b0, 15'h0001, 16'h0000, 16'h0019, 3, 1'b0);
        do_access(0, 1'b1, 1'b1, 15'h0101, 16'hfff0, 16'h0000, 2, 1'b0);
        do_access(0, 1'b0, 1'b0, 15'h0101, 16'h0000, 16'hfff0, 3, 1'b0);

        // Simultaneous requests: A first, then B.
        @(negedge clk);
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 15'h0002;
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 15'h0003;
        e = '{port: 1'b0, data: 16'h1002}; sb.push_back(e);
        e = '{port: 1'b1, data: 16'h1003}; sb.push_back(e);
        wait_acks(0, 2, 1'b1);

        // Both held: grant order A,A,A,A,B,A.
        @(negedge clk);
        a_req[0] = 1'b1; a_addr[0] = 15'h0004;
        b_req[0] = 1'b1; b_addr[0] = 15'h0005;
        for (int i = 0; i < 4; i++) begin
            e = '{port: 1'b0, data: 16'h1004}; sb.push_back(e);
        end
        e = '{port: 1'b1, data: 16'h1005}; sb.push_back(e);
        e = '{port: 1'b0, data: 16'h1004}; sb.push_back(e);
        wait_acks(0, 6, 1'b0);
        a_req[0] = 1'b0;
        b_req[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("starve_idle", {31'd0, busy[0]}, 32'd0);

        // Reset during the ACCESS phase of a read.
        @(negedge clk);
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 15'h0001;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
        a_req[0] = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ack", {31'd0, a_ack[0]}, 32'd0);
        chk("rst_mid_we_busy", {30'd0, mem_we[0], busy[0]}, 32'd0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_no_late_ack", {30'd0, a_ack[0], b_ack[0]}, 32'd0);
        end
        do_access(0, 1'b0, 1'b0, 15'h0001, 16'h0000, 16'h0019, 3, 1'b0);

        // Read latency 3; request dropped early still completes.
        do_access(1, 1'b0, 1'b0, 15'h0001, 16'h0000, 16'h0019, 5, 1'b0);
        do_access(1, 1'b0, 1'b1, 15'h0007, 16'hbeef, 16'h0000, 2, 1'b1);
        do_access(1, 1'b0, 1'b0, 15'h0007, 16'h0000, 16'hbeef, 5, 1'b1);
        do_access(1, 1'b1, 1'b0, 15'h7fff, 16'h0000, 16'h11ff, 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
